// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the IF/MEM memory port arbiter
package mem_arb_pkg;

    // Sequencer states; only IDLE arbitrates between the two stages
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Which pipeline stage owns the access in flight
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Byte-enable pattern meaning "read"
    localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational data-first pick with fetch starvation override
import mem_arb_pkg::*;

module mem_arb_pick #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output owner_t           grant
);

    logic starved;

    // Data wins by default; fetch is forced once data has won STARVE_MAX contested rounds
    always_comb begin
        starved = (starve_cnt == CNT_W'(STARVE_MAX));
        grant   = OWN_I;
        if (d_req && !(i_req && starved)) begin
            grant = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM sequencer shared by IF and MEM stages
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              if_stall,
    output logic              mem_stall,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam int LAT_W = $clog2(MEM_LAT + 1);

    arb_state_t        state;
    arb_state_t        state_next;
    owner_t            owner;
    owner_t            grant;
    logic [ADDR_W-1:0] lat_addr;
    logic [3:0]        lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  starve_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              any_req;
    logic              take;
    logic              last_wait;

    assign any_req   = i_req | d_req;
    assign take      = (state == IDLE) && any_req;
    assign last_wait = (state == WAIT) && (lat_cnt == '0);

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .grant      (grant)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all RAM/ack/stall outputs, decoded from the current state
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = WE_NONE;
        mem_addr   = '0;
        mem_wdata  = '0;
        i_ack      = 1'b0;
        d_ack      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en     = 1'b1;
                mem_we     = lat_we;
                mem_addr   = lat_addr;
                mem_wdata  = lat_wdata;
                state_next = WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                i_ack      = (owner == OWN_I);
                d_ack      = (owner == OWN_D);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if_stall  = i_req & ~i_ack;
        mem_stall = d_req & ~d_ack;
    end

    // Latch the winner's request at grant time; fetches always read with zero write data
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_I;
            lat_addr  <= '0;
            lat_we    <= WE_NONE;
            lat_wdata <= '0;
        end else if (take) begin
            owner <= grant;
            if (grant == OWN_D) begin
                lat_addr  <= d_addr;
                lat_we    <= d_we;
                lat_wdata <= d_wdata;
            end else begin
                lat_addr  <= i_addr;
                lat_we    <= WE_NONE;
                lat_wdata <= '0;
            end
        end
    end

    // Count contested rounds lost by fetch; any fetch grant clears the debt
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (take) begin
            if (grant == OWN_I) begin
                starve_cnt <= '0;
            end else if (i_req && (starve_cnt != CNT_W'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // RAM latency down-counter, loaded as the strobe goes out
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (state == ISSUE) begin
            lat_cnt <= LAT_W'(MEM_LAT - 1);
        end else if ((state == WAIT) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
        end
    end

    // Capture read data for the owner on the final wait cycle; stores leave d_rdata alone
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (last_wait) begin
            if (owner == OWN_I) begin
                i_rdata <= mem_rdata;
            end else if (lat_we == WE_NONE) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ack, d_ack, if_stall, mem_stall, mem_en;
    logic [3:0]  mem_we;

    logic [31:0] l3_i_rdata, l3_d_rdata, l3_mem_addr, l3_mem_wdata;
    logic        l3_i_ack, l3_d_ack, l3_if_stall, l3_mem_stall, l3_mem_en;
    logic [3:0]  l3_mem_we;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .if_stall(if_stall), .mem_stall(mem_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(l3_i_rdata), .i_ack(l3_i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(l3_d_rdata), .d_ack(l3_d_ack),
        .if_stall(l3_if_stall), .mem_stall(l3_mem_stall),
        .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
        .mem_wdata(l3_mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          is_d;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [3:0]  exp_mwe;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ireq, input logic dreq);
        rst = 1'b1;
        i_req = ireq;
        d_req = dreq;
        cyc();
        cyc();
    endtask

    task automatic do_access(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        cyc();
        i_req     = !v.is_d;
        d_req     = v.is_d;
        i_addr    = v.is_d ? 32'h0000_0FF0 : v.addr;
        d_addr    = v.is_d ? v.addr : 32'h0000_0FF4;
        d_we      = v.we;
        d_wdata   = v.wdata;
        mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk({tag, "_T_stall"}, v.is_d ? mem_stall : if_stall, 1);
        chk({tag, "_T_mem_en"}, mem_en, 0);
        cyc();
        #1;
        chk({tag, "_T1_mem_en"}, mem_en, 1);
        chk({tag, "_T1_mem_addr"}, mem_addr, v.addr);
        chk({tag, "_T1_mem_we"}, mem_we, v.exp_mwe);
        chk({tag, "_T1_mem_wdata"}, mem_wdata, v.exp_mwdata);
        cyc();
        mem_rdata = v.rd;
        #1;
        chk({tag, "_T2_mem_en"}, mem_en, 0);
        chk({tag, "_T2_ack"}, {i_ack, d_ack}, 0);
        chk({tag, "_T2_stall"}, v.is_d ? mem_stall : if_stall, 1);
        cyc();
        mem_rdata = 32'hBAD1_BAD1;
        #1;
        chk({tag, "_T3_ack"}, {i_ack, d_ack}, v.is_d ? 2'b01 : 2'b10);
        chk({tag, "_T3_stall"}, {if_stall, mem_stall}, 0);
        chk({tag, "_T3_i_rdata"}, i_rdata, v.exp_i);
        chk({tag, "_T3_d_rdata"}, d_rdata, v.exp_d);
        cyc();
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        chk({tag, "_T4_ack"}, {i_ack, d_ack}, 0);
    endtask

    initial begin
        bit exp_own [6];
        bit got;

        vecs[0] = '{1'b0, 4'b0000, 32'h40, 32'h0, 32'h8C01_0004, 4'b0000, 32'h0, 32'h8C01_0004, 32'h0};
        vecs[1] = '{1'b1, 4'b1111, 32'h08, 32'hDEAD_BEEF, 32'h1111_1111, 4'b1111, 32'hDEAD_BEEF, 32'h8C01_0004, 32'h0};
        vecs[2] = '{1'b1, 4'b0000, 32'h10, 32'h0, 32'h1234_5678, 4'b0000, 32'h0, 32'h8C01_0004, 32'h1234_5678};
        vecs[3] = '{1'b1, 4'b0011, 32'h14, 32'hCAFE_F00D, 32'h2222_2222, 4'b0011, 32'hCAFE_F00D, 32'h8C01_0004, 32'h1234_5678};
        vecs[4] = '{1'b0, 4'b0000, 32'h44, 32'h5555_5555, 32'h00A0_0093, 4'b0000, 32'h0, 32'h00A0_0093, 32'h1234_5678};
        vecs[5] = '{1'b1, 4'b0000, 32'h20, 32'h0, 32'hFFFF_0000, 4'b0000, 32'h0, 32'h00A0_0093, 32'hFFFF_0000};

        i_addr = 32'h0; d_addr = 32'h8; d_we = 4'b0; d_wdata = 32'h0; mem_rdata = 32'hBAD0_BAD0;

        // Reset with both requests asserted
        do_reset(1'b1, 1'b1);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_acks", {i_ack, d_ack}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        chk("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_T_mem_en", mem_en, 0);
        cyc();
        #1;
        chk("post_rst_T1_mem_en", mem_en, 1);
        chk("post_rst_T1_data_wins", mem_addr, 32'h8);

        // Isolated transactions from the vector table
        do_reset(1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            do_access(vecs[k], k);
        end

        // Starvation: both held; four data grants, then fetch, then data again
        do_reset(1'b0, 1'b0);
        rst = 1'b0;
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        i_addr = 32'h100; d_addr = 32'h200; d_we = 4'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            got = 1'b0;
            for (int w = 0; w < 8 && !got; w++) begin
                cyc();
                #1;
                if (i_ack || d_ack) got = 1'b1;
            end
            if (!got) begin
                n_cmp++;
                n_bad++;
                $display("FAIL starve_timeout_%0d: got no ack required ack within 8 cycles", g);
            end else begin
                chk($sformatf("starve_grant_%0d", g), {i_ack, d_ack}, exp_own[g] ? 2'b01 : 2'b10);
            end
        end
        i_req = 1'b0; d_req = 1'b0;

        // MEM_LAT=3 single read
        do_reset(1'b0, 1'b0);
        rst = 1'b0;
        cyc();
        d_req = 1'b1; d_we = 4'b0; d_addr = 32'h30; mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("l3_T_mem_en", l3_mem_en, 0);
        cyc(); #1;
        chk("l3_T1_mem_en", l3_mem_en, 1);
        chk("l3_T1_bus", {l3_mem_we, l3_mem_addr, l3_mem_wdata}, {4'b0, 32'h30, 32'h0});
        cyc(); #1;
        chk("l3_T2_ack", l3_d_ack, 0);
        cyc(); #1;
        chk("l3_T3_ack", l3_d_ack, 0);
        cyc();
        mem_rdata = 32'h5A5A_1234;
        #1;
        chk("l3_T4_ack", l3_d_ack, 0);
        chk("l3_T4_stall", l3_mem_stall, 1);
        cyc();
        mem_rdata = 32'hBAD1_BAD1;
        #1;
        chk("l3_T5_ack", {l3_i_ack, l3_d_ack}, 2'b01);
        chk("l3_T5_d_rdata", l3_d_rdata, 32'h5A5A_1234);
        chk("l3_T5_fetch_side", {l3_if_stall, l3_mem_stall, l3_i_rdata}, 0);
        cyc();
        d_req = 1'b0;

        // Reset during WAIT aborts without an ack
        do_reset(1'b0, 1'b0);
        rst = 1'b0;
        cyc();
        i_req = 1'b1; i_addr = 32'h80;
        #1;
        cyc(); #1;
        chk("midrst_issue", mem_en, 1);
        cyc();
        rst = 1'b1;
        mem_rdata = 32'h7777_7777;
        #1;
        chk("midrst_wait_ack", i_ack, 0);
        cyc();
        rst = 1'b0;
        i_req = 1'b0;
        #1;
        chk("midrst_after_ack", {i_ack, d_ack}, 0);
        chk("midrst_after_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        chk("midrst_after_rdata", i_rdata, 0);
        cyc(); #1;
        chk("midrst_idle", {mem_en, i_ack}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
